// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding, the
// default operand width and the divide-by-zero quotient fill bit.
package iterative_divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Divide-by-zero quotient is all ones at any width: {WIDTH{DIV0_Q_FILL}}.
    localparam logic DIV0_Q_FILL = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage : iterative_divider_pkg

// File: rtl/iterative_divider_step.sv
// One combinational restoring-division iteration.
// Ports:
//   i_rem     : partial remainder in (always < i_divisor)
//   i_quo     : quotient/dividend shift register in
//   i_divisor : divisor magnitude
//   o_rem_c   : partial remainder out
//   o_quo_c   : quotient shift register out (new bit in LSB)
module iterative_divider_step
    import iterative_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_c,
    output logic [WIDTH-1:0] o_quo_c
);

    // WIDTH+1 bits: shifting a remainder < divisor can exceed WIDTH bits.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});

    // Difference is below the divisor, so it always fits back in WIDTH bits.
    assign o_rem_c = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo_c = {i_quo[WIDTH-2:0], w_ge};

endmodule : iterative_divider_step

// File: rtl/iterative_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU (quotient->LO, remainder->HI).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_start      : request a divide (sampled in IDLE only)
//   i_signed     : 1 = signed DIV, 0 = DIVU
//   i_dividend   : dividend, sampled with i_start
//   i_divisor    : divisor, sampled with i_start
//   i_flush      : abort any operation, return to IDLE
//   o_busy       : operation in progress (CALC or DONE)
//   o_done       : one-cycle completion pulse, results valid in that cycle
//   o_quotient   : registered quotient
//   o_remainder  : registered remainder
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic             w_finish;
    logic             w_dd_neg;
    logic             w_dv_neg;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_dd_abs;
    logic [WIDTH-1:0] w_dv_abs;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;

    // Operand magnitudes; negation wraps, so MIN stays MIN and MIN/-1 needs no special case.
    assign w_dd_neg   = i_signed & i_dividend[WIDTH-1];
    assign w_dv_neg   = i_signed & i_divisor[WIDTH-1];
    assign w_dd_abs   = w_dd_neg ? -i_dividend : i_dividend;
    assign w_dv_abs   = w_dv_neg ? -i_divisor  : i_divisor;
    assign w_div_zero = (i_divisor == '0);

    iterative_divider_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dvs),
        .o_rem_c   (w_step_rem),
        .o_quo_c   (w_step_quo)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; flush overrides everything, including a same-cycle start.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_finish     = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (i_flush) begin
            w_next_state = S_IDLE;
            w_accept     = 1'b0;
            w_finish     = 1'b0;
        end
    end

    // Datapath: operand latch, per-cycle step, and result load on DONE entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_dd_abs;
            r_dvs   <= w_dv_abs;
            r_neg_q <= w_dd_neg ^ w_dv_neg;
            r_neg_r <= w_dd_neg;
            if (w_div_zero) begin
                r_quotient  <= {WIDTH{DIV0_Q_FILL}};
                r_remainder <= i_dividend;
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            if (w_finish) begin
                r_quotient  <= r_neg_q ? -w_step_quo : w_step_quo;
                r_remainder <= r_neg_r ? -w_step_rem : w_step_rem;
            end
        end
    end

    // Status decoded straight from the state register.
    assign o_busy      = (r_state == S_CALC) || (r_state == S_DONE);
    assign o_done      = (r_state == S_DONE);
    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;

endmodule : iterative_divider
